// File: rtl/tlc_phase_controller.sv
// -----------------------------------------------------------------------------
// tlc_phase_controller
//
// Moore phase sequencer for a two-road intersection with a pedestrian crossing.
// Main road owns the crossing by default. The side-road car sensor and a
// latched pedestrian request can claim it, and an emergency input pre-empts
// everything by parking the intersection in all-red (HOLD). One clk cycle is
// one second on the board.
//
// Ports
//   clk        in   divided system clock, rising edge
//   reset      in   asynchronous reset, active low (0 = in reset)
//   car_side   in   side-road vehicle sensor, level
//   ped_req    in   pedestrian button, latched internally until served
//   emergency  in   emergency pre-emption, level
//   main_light out  main-road head {R,Y,G}, one-hot
//   side_light out  side-road head {R,Y,G}, one-hot
//   walk       out  pedestrian WALK lamp
//   ped_ack    out  one-cycle pulse on the first cycle of WALK
//   state      out  current state encoding
//   timer      out  cycles remaining in the current state
// -----------------------------------------------------------------------------
module tlc_phase_controller #(
  parameter int T_MAIN_MIN = 10,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 1,
  parameter int T_SIDE     = 6,
  parameter int T_WALK     = 5,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_side,
  input  logic             ped_req,
  input  logic             emergency,
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic             walk,
  output logic             ped_ack,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] timer
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    ALL_R1 = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    ALL_R2 = 3'd5,
    WALK   = 3'd6,
    HOLD   = 3'd7
  } state_e;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_pending_q, ped_pending_d;
  logic             ped_ack_q, ped_ack_d;
  logic             timer_zero;
  logic             enter_walk;

  // Dwell minus one: the timer counts down to zero, so zero is the last cycle.
  function automatic logic [CNT_W-1:0] load_value(input state_e s);
    logic [CNT_W-1:0] v;
    v = '0;
    case (s)
      MAIN_G:         v = CNT_W'(T_MAIN_MIN - 1);
      MAIN_Y, SIDE_Y: v = CNT_W'(T_YELLOW - 1);
      ALL_R1, ALL_R2: v = CNT_W'(T_ALLRED - 1);
      SIDE_G:         v = CNT_W'(T_SIDE - 1);
      WALK:           v = CNT_W'(T_WALK - 1);
      HOLD:           v = '0;
      default:        v = '0;
    endcase
    return v;
  endfunction

  assign timer_zero = (timer_q == '0);

  // Next-state logic. Yellow and all-red never look at emergency mid-dwell,
  // so a clearance interval is always served in full.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      MAIN_G: begin
        if (emergency)                                    state_d = MAIN_Y;
        else if (timer_zero && (car_side || ped_pending_q)) state_d = MAIN_Y;
      end
      MAIN_Y: if (timer_zero) state_d = ALL_R1;
      ALL_R1: begin
        if (timer_zero) begin
          if (emergency)          state_d = HOLD;
          else if (car_side)      state_d = SIDE_G;
          else if (ped_pending_q) state_d = WALK;
          else                    state_d = MAIN_G;
        end
      end
      SIDE_G: if (emergency || timer_zero) state_d = SIDE_Y;
      SIDE_Y: if (timer_zero) state_d = ALL_R2;
      ALL_R2: begin
        if (timer_zero) begin
          if (emergency)          state_d = HOLD;
          else if (ped_pending_q) state_d = WALK;
          else                    state_d = MAIN_G;
        end
      end
      WALK: begin
        if (emergency)       state_d = HOLD;
        else if (timer_zero) state_d = MAIN_G;
      end
      HOLD: if (!emergency) state_d = ALL_R2;
      default: state_d = MAIN_G;
    endcase
  end

  // Timer reloads on any state change; while staying it counts down and sticks
  // at zero, which is the saturating behaviour MAIN_G and HOLD rely on.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)  timer_d = load_value(state_d);
    else if (!timer_zero)    timer_d = timer_q - 1'b1;
  end

  // A request arriving on the very edge that enters WALK is absorbed by that
  // WALK; otherwise requests accumulate into a single pending flag.
  always_comb begin
    enter_walk    = (state_d == WALK) && (state_q != WALK);
    ped_pending_d = enter_walk ? 1'b0 : (ped_pending_q | ped_req);
    ped_ack_d     = enter_walk;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q       <= MAIN_G;
      timer_q       <= CNT_W'(T_MAIN_MIN - 1);
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  // Lamp decode from the registered state only, so heads never glitch on
  // input changes and at most one head is non-red by construction.
  always_comb begin
    main_light = LIGHT_R;
    side_light = LIGHT_R;
    walk       = 1'b0;
    case (state_q)
      MAIN_G:  main_light = LIGHT_G;
      MAIN_Y:  main_light = LIGHT_Y;
      SIDE_G:  side_light = LIGHT_G;
      SIDE_Y:  side_light = LIGHT_Y;
      WALK:    walk       = 1'b1;
      default: ;
    endcase
  end

  assign ped_ack = ped_ack_q;
  assign state   = state_q;
  assign timer   = timer_q;

endmodule

// File: tb/tb_tlc_phase_controller.sv
module tb_tlc_phase_controller;

  localparam int CNT_W = 5;

  logic             clk;
  logic             reset;
  logic             car_side;
  logic             ped_req;
  logic             emergency;
  logic [2:0]       main_light;
  logic [2:0]       side_light;
  logic             walk;
  logic             ped_ack;
  logic [2:0]       state;
  logic [CNT_W-1:0] timer;

  typedef struct packed {
    logic [2:0]       st;
    logic [CNT_W-1:0] tmr;
    logic [2:0]       ml;
    logic [2:0]       sl;
    logic             wk;
    logic             ack;
  } obs_t;

  obs_t obs;
  obs_t exp_v;
  obs_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  tlc_phase_controller #(
    .T_MAIN_MIN(10), .T_YELLOW(3), .T_ALLRED(1), .T_SIDE(6), .T_WALK(5), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .car_side   (car_side),
    .ped_req    (ped_req),
    .emergency  (emergency),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .ped_ack    (ped_ack),
    .state      (state),
    .timer      (timer)
  );

  assign obs = {state, timer, main_light, side_light, walk, ped_ack};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs for one cycle spent in state st with the given timer.
  function automatic obs_t mk(input int st, input int t, input logic ack);
    obs_t o;
    o.st  = 3'(st);
    o.tmr = CNT_W'(t);
    o.ml  = 3'b100;
    o.sl  = 3'b100;
    o.wk  = (st == 6);
    o.ack = ack;
    case (st)
      0: o.ml = 3'b001;
      1: o.ml = 3'b010;
      3: o.sl = 3'b001;
      4: o.sl = 3'b010;
      default: ;
    endcase
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d t=%0d m=%b s=%b w=%b a=%b", o.st, o.tmr, o.ml, o.sl, o.wk, o.ack);
  endfunction

  // Push n cycles in state st, timer counting down from t0 and sticking at 0.
  task automatic push_run(input int st, input int t0, input int n, input logic ack_first = 1'b0);
    for (int i = 0; i < n; i++)
      sb.push_back(mk(st, (t0 > i) ? t0 - i : 0, ack_first && (i == 0)));
  endtask

  // Leaves the bench in the low phase of cycle 0 after a clean reset.
  task automatic do_reset();
    @(negedge clk);
    car_side  = 1'b0;
    ped_req   = 1'b0;
    emergency = 1'b0;
    reset     = 1'b0;
    #2;
    reset     = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; car_side = 1'b0; ped_req = 1'b0; emergency = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_v = mk(0, 9, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL reset_async got %s want %s", fmt(obs), fmt(exp_v));
    end
    @(negedge clk);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL reset_held got %s want %s", fmt(obs), fmt(exp_v));
    end
    reset = 1'b1;
  endtask

  task automatic test_side_cycle();
    do_reset();
    for (int p = 0; p < 2; p++) begin
      push_run(0, 9, 10); push_run(1, 2, 3); push_run(2, 0, 1);
      push_run(3, 5, 6);  push_run(4, 2, 3); push_run(5, 0, 1);
    end
    push_run(0, 9, 1);
    for (int c = 0; c < 49; c++) begin
      car_side = 1'b1;
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL side_cycle cyc=%0d got %s want <none>", c, fmt(obs));
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL side_cycle cyc=%0d got %s want %s", c, fmt(obs), fmt(exp_v));
        end
      end
      @(negedge clk); #2;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL side_cycle leftover got %0d want 0", sb.size()); end
  endtask

  task automatic test_idle();
    do_reset();
    push_run(0, 9, 50);
    for (int c = 0; c < 50; c++) begin
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL idle cyc=%0d got %s want <none>", c, fmt(obs));
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL idle cyc=%0d got %s want %s", c, fmt(obs), fmt(exp_v));
        end
      end
      @(negedge clk); #2;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL idle leftover got %0d want 0", sb.size()); end
  endtask

  task automatic test_ped();
    do_reset();
    push_run(0, 9, 10); push_run(1, 2, 3); push_run(2, 0, 1);
    push_run(6, 4, 5, 1'b1); push_run(0, 9, 15);
    for (int c = 0; c < 34; c++) begin
      ped_req = (c == 2);
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL ped cyc=%0d got %s want <none>", c, fmt(obs));
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL ped cyc=%0d got %s want %s", c, fmt(obs), fmt(exp_v));
        end
      end
      @(negedge clk); #2;
    end
    ped_req = 1'b0;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL ped leftover got %0d want 0", sb.size()); end
  endtask

  task automatic test_emergency_side();
    do_reset();
    push_run(0, 9, 10); push_run(1, 2, 3); push_run(2, 0, 1);
    push_run(3, 5, 3);  push_run(4, 2, 3); push_run(5, 0, 1);
    push_run(7, 0, 4);  push_run(5, 0, 1); push_run(0, 9, 6);
    for (int c = 0; c < 32; c++) begin
      car_side  = (c < 14);
      emergency = (c >= 16 && c <= 23);
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL emerg_side cyc=%0d got %s want <none>", c, fmt(obs));
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL emerg_side cyc=%0d got %s want %s", c, fmt(obs), fmt(exp_v));
        end
      end
      @(negedge clk); #2;
    end
    emergency = 1'b0;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL emerg_side leftover got %0d want 0", sb.size()); end
  endtask

  task automatic test_emergency_main();
    do_reset();
    push_run(0, 9, 5); push_run(1, 2, 3); push_run(2, 0, 1);
    push_run(7, 0, 2); push_run(5, 0, 1); push_run(0, 9, 4);
    for (int c = 0; c < 16; c++) begin
      emergency = (c >= 4 && c <= 9);
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL emerg_main cyc=%0d got %s want <none>", c, fmt(obs));
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL emerg_main cyc=%0d got %s want %s", c, fmt(obs), fmt(exp_v));
        end
      end
      @(negedge clk); #2;
    end
    emergency = 1'b0;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL emerg_main leftover got %0d want 0", sb.size()); end
  endtask

  task automatic test_emergency_walk();
    do_reset();
    push_run(0, 9, 10); push_run(1, 2, 3); push_run(2, 0, 1);
    push_run(6, 4, 2, 1'b1); push_run(7, 0, 1); push_run(5, 0, 1); push_run(0, 9, 12);
    for (int c = 0; c < 30; c++) begin
      ped_req   = (c == 0);
      emergency = (c == 15);
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL emerg_walk cyc=%0d got %s want <none>", c, fmt(obs));
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL emerg_walk cyc=%0d got %s want %s", c, fmt(obs), fmt(exp_v));
        end
      end
      @(negedge clk); #2;
    end
    ped_req = 1'b0; emergency = 1'b0;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL emerg_walk leftover got %0d want 0", sb.size()); end
  endtask

  // Car and pedestrian both waiting: side first, then WALK once. The pulse at
  // cycle 23 lands on the WALK-entry edge and is absorbed, so no second WALK.
  task automatic test_back_to_back();
    do_reset();
    push_run(0, 9, 10); push_run(1, 2, 3); push_run(2, 0, 1);
    push_run(3, 5, 6);  push_run(4, 2, 3); push_run(5, 0, 1);
    push_run(6, 4, 5, 1'b1); push_run(0, 9, 13);
    for (int c = 0; c < 42; c++) begin
      car_side = (c <= 13);
      ped_req  = (c == 5 || c == 7 || c == 23);
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL back_to_back cyc=%0d got %s want <none>", c, fmt(obs));
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL back_to_back cyc=%0d got %s want %s", c, fmt(obs), fmt(exp_v));
        end
      end
      @(negedge clk); #2;
    end
    car_side = 1'b0; ped_req = 1'b0;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL back_to_back leftover got %0d want 0", sb.size()); end
  endtask

  // Reset mid-WALK with a fresh request latched during WALK: outputs must
  // return immediately, and the dropped latch means no yellow afterwards.
  task automatic test_reset_mid_walk();
    do_reset();
    push_run(0, 9, 10); push_run(1, 2, 3); push_run(2, 0, 1); push_run(6, 4, 2, 1'b1);
    for (int c = 0; c < 16; c++) begin
      ped_req = (c == 2 || c == 15);
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL reset_walk cyc=%0d got %s want <none>", c, fmt(obs));
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL reset_walk cyc=%0d got %s want %s", c, fmt(obs), fmt(exp_v));
        end
      end
      @(negedge clk); #2;
    end
    ped_req = 1'b0;
    reset   = 1'b0;
    #1;
    exp_v = mk(0, 9, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL reset_walk_async got %s want %s", fmt(obs), fmt(exp_v));
    end
    reset = 1'b1;
    sb.delete();
    push_run(0, 9, 14);
    for (int c = 0; c < 14; c++) begin
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL reset_walk_after cyc=%0d got %s want <none>", c, fmt(obs));
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL reset_walk_after cyc=%0d got %s want %s", c, fmt(obs), fmt(exp_v));
        end
      end
      @(negedge clk); #2;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL reset_walk leftover got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_side_cycle();
    test_idle();
    test_ped();
    test_emergency_side();
    test_emergency_main();
    test_emergency_walk();
    test_back_to_back();
    test_reset_mid_walk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlc_phase_controller.md
# tlc_phase_controller

Phase sequencer for the traffic light controller: a Moore state machine, clocked by the divided clock from the clock-generation block (one `clk` cycle = one second on the board). It drives the main-road and side-road signal heads and the pedestrian WALK lamp. It arbitrates the crossing between three requesters: main-road traffic (default owner), the side-road car sensor and a pedestrian button. An emergency input overrides all of them.

## Interface
Parameters:
- `T_MAIN_MIN`, 10: minimum main-green dwell, cycles (≥1)
- `T_YELLOW`, 3: yellow dwell, cycles (≥1)
- `T_ALLRED`, 1: all-red clearance dwell, cycles (≥1)
- `T_SIDE`, 6: side-green dwell, cycles (≥1)
- `T_WALK`, 5: pedestrian WALK dwell, cycles (≥1)
- `CNT_W`, 5: timer width; must hold max(T_*)−1

Ports:
- `clk` in 1: divided system clock, rising edge
- `reset` in 1: asynchronous, active-low; 0 = reset asserted
- `car_side` in 1: side-road vehicle sensor, level
- `ped_req` in 1: pedestrian button, sampled every cycle, latched internally
- `emergency` in 1: emergency pre-emption, level
- `main_light` out 3: {R,Y,G}, one-hot
- `side_light` out 3: {R,Y,G}, one-hot
- `walk` out 1: WALK lamp
- `ped_ack` out 1: one-cycle pulse, pedestrian request served
- `state` out 3: current state encoding
- `timer` out CNT_W: cycles remaining in current state

## Operation
- States (encoding):
  - MAIN_G=0, MAIN_Y=1, ALL_R1=2, SIDE_G=3, SIDE_Y=4, ALL_R2=5, WALK=6, HOLD=7.
- Lights are decoded from the registered `state` only:
  - main G in MAIN_G; main Y in MAIN_Y; main R otherwise.
  - side G in SIDE_G; side Y in SIDE_Y; side R otherwise.
  - `walk`=1 only in WALK.
- Timer:
  - loaded with T_x−1 on entry to a timed state, then decrements by 1 per cycle. Dwell = T_x cycles.
  - In MAIN_G it saturates at 0. In HOLD it is 0.
- `ped_pending`:
  - set by `ped_req`=1 in any state except the cycle of entry into WALK.
  - cleared on entry into WALK.
- Transitions (evaluated at each rising edge):
  - MAIN_G: `emergency` → MAIN_Y immediately (timer ignored). Otherwise, at timer==0, if `car_side`|`ped_pending` → MAIN_Y. Otherwise stay.
  - MAIN_Y: at timer==0 → ALL_R1.
  - ALL_R1: at timer==0: `emergency` → HOLD, else `car_side` → SIDE_G, else `ped_pending` → WALK, else → MAIN_G.
  - SIDE_G: `emergency` → SIDE_Y immediately. At timer==0 → SIDE_Y.
  - SIDE_Y: at timer==0 → ALL_R2.
  - ALL_R2: at timer==0: `emergency` → HOLD, else `ped_pending` → WALK, else → MAIN_G.
  - WALK: `emergency` → HOLD immediately. At timer==0 → MAIN_G.
  - HOLD: stay while `emergency`=1. On `emergency`=0 → ALL_R2 (clearance before main green).
- Yellow and all-red always complete their full dwell, even under emergency.

## Timing
- Reset (`reset`=0, async) values:
  - `state`=MAIN_G, `timer`=T_MAIN_MIN−1
  - `main_light`=001, `side_light`=100
  - `walk`=0, `ped_ack`=0, `ped_pending`=0
- Inputs are synchronous to `clk`. A condition sampled at edge k takes effect in `state`/lights after edge k; there is no additional latency.
- `ped_ack`:
  - registered; high for exactly the first cycle spent in WALK.
  - never high outside WALK.
- `ped_req` pulses:
  - a 1-cycle pulse is never lost, except one coinciding with WALK entry.
  - multiple pulses before service collapse to one WALK.
- Simultaneous `car_side` and `ped_pending` at ALL_R1:
  - side road is served first.
  - WALK follows via ALL_R2 if `ped_pending` is still set.
- Invariant: at most one head shows non-red in any cycle. `walk`=1 implies both heads red.
- `reset` asserted mid-phase forces MAIN_G immediately. The pedestrian latch is dropped.

## Test plan
- Reset, `car_side`=1 held:
  - MAIN_G 10 cycles, MAIN_Y 3, ALL_R1 1, SIDE_G 6, SIDE_Y 3, ALL_R2 1, then MAIN_G.
  - Period 24 cycles, repeating.
- No requests for 50 cycles: stays in MAIN_G, `timer` saturates at 0, `main_light`=001 throughout.
- 1-cycle `ped_req` at cycle 2, `car_side`=0:
  - MAIN_Y at cycle 10, ALL_R1 at 13, WALK entered at 14 with `ped_ack`=1 for one cycle.
  - `walk`=1 for 5 cycles, then MAIN_G at 19.
- `emergency`=1 at cycle 3 of SIDE_G:
  - SIDE_Y next cycle (3 cycles), ALL_R2 1, then HOLD, both heads 100.
  - Release `emergency`: ALL_R2 1 cycle, then MAIN_G.
- `car_side`=1 and `ped_req` pulse both before MAIN_G expiry:
  - order is SIDE_G → SIDE_Y → ALL_R2 → WALK → MAIN_G.
  - `ped_ack` pulses once.
- `reset`=0 asynchronously mid-WALK: outputs return to reset values without waiting for a `clk` edge. `ped_pending`=0.
